echo_decim: RTL and testbench

ECHO_DECIM -- requirements
Module: echo_decim

---
 rtl/echo_decim_pkg.sv | 30 +++
 rtl/echo_decim_line_fifo.sv | 64 ++++++
 rtl/echo_decim.sv | 205 ++++++++++++++++++++
 tb/tb_echo_decim.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_decim_pkg.sv
// Shared definitions for the echo decimator: FSM states, datapath widths
// and the magnitude / output saturation helpers.
package echo_decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int DAS_W = 15;
    localparam int MAG_W = 14;
    localparam int OUT_W = 8;

    // |x| of a two's complement sample, clipped so -16384 maps to 16383
    function automatic logic [MAG_W-1:0] abs_sat(input logic [DAS_W-1:0] x);
        logic [DAS_W-1:0] a;
        a = x[DAS_W-1] ? ((~x) + {{(DAS_W-1){1'b0}}, 1'b1}) : x;
        return a[DAS_W-1] ? {MAG_W{1'b1}} : a[MAG_W-1:0];
    endfunction

    // Drop shift LSBs, then clip to the 8-bit output range
    function automatic logic [OUT_W-1:0] sat_out(input logic [MAG_W-1:0] m, input int shift);
        logic [MAG_W-1:0] s;
        s = m >> shift;
        return (|s[MAG_W-1:OUT_W]) ? {OUT_W{1'b1}} : s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/echo_decim_line_fifo.sv
// line_fifo: DEPTH x WIDTH simple dual-port line buffer. One write port,
// one read port with a single registered read stage. Pointers carry an
// extra wrap bit so full and empty are distinguishable.
module line_fifo #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             one_left
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      fill;
    logic [WIDTH-1:0] rd_data_q;
    logic             wr_ok;
    logic             rd_ok;

    assign fill     = wr_ptr_q - rd_ptr_q;
    assign empty    = (fill == '0);
    assign full     = fill[AW];
    assign one_left = (fill == {{AW{1'b0}}, 1'b1});
    assign wr_ok    = wr_en & ~full;
    assign rd_ok    = rd_en & ~empty;
    assign rd_data  = rd_data_q;

    // RAM write port; contents are deliberately never cleared
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Registered read; output register resets to zero
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Write and read pointers
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (rd_ok) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/echo_decim.sv
// echo_decim: peak-detecting decimator for one receive line of beamformed
// samples. Each window of DECIM samples collapses to its peak magnitude,
// compressed to 8 bits and queued in a line buffer; the buffer drains over
// a valid/ready port once the receive window closes.
// Optional build macro COHERENCE_WEIGHT_EN: weight each magnitude by the
// coherence factor through one extra pipeline stage.
module echo_decim
    import echo_decim_pkg::*;
#(
    parameter int DECIM     = 8,
    parameter int DEPTH     = 2048,
    parameter int OUT_SHIFT = 6
) (
    input  logic             AD_CLK,
    input  logic             Reset,
    input  logic             So_Gate,
    input  logic [DAS_W-1:0] DAS_Value,
    input  logic [7:0]       Coheren_Coff,
    input  logic [7:0]       Line_Num,
    output logic [OUT_W-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Out_Last,
    output logic [7:0]       Out_Line,
    output logic             Ovf
);

    localparam int CNT_W = $clog2(DECIM + 1);

    state_e             state_q, state_d;
    logic               gate_prev_q;
    logic               gate_rise;
    logic               line_start;
    logic               sample_take;
    logic [MAG_W-1:0]   mag;

    logic               acc_vld;
    logic [MAG_W-1:0]   acc_mag;
    logic               pipe_busy;

    logic [MAG_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAG_W-1:0]   cur_max, new_max;
    logic [CNT_W-1:0]   cur_cnt;
    logic               wr_en;
    logic [OUT_W-1:0]   wr_word;

    logic               rd_en;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               xfer;
    logic [7:0]         out_line_q;
    logic               ovf_q;

    logic               fifo_full, fifo_empty, fifo_one_left;

    assign gate_rise   = So_Gate & ~gate_prev_q;
    assign line_start  = (state_q == ST_IDLE) && gate_rise;
    assign sample_take = line_start || ((state_q == ST_ACQ) && So_Gate);
    assign mag         = abs_sat(DAS_Value);
    assign xfer        = out_valid_q & Out_Ready;

`ifdef COHERENCE_WEIGHT_EN
    logic [MAG_W+7:0] prod;
    logic [7:0]       unused_prod_lsb;
    logic             wpipe_vld_q;
    logic [MAG_W-1:0] wpipe_mag_q;

    assign prod            = {8'b0, mag} * {{MAG_W{1'b0}}, Coheren_Coff};
    assign unused_prod_lsb = prod[7:0];

    // Weighting stage: the accumulator sees each sample one cycle later
    always_ff @(posedge AD_CLK) begin
        if (Reset) begin
            wpipe_vld_q <= 1'b0;
            wpipe_mag_q <= '0;
        end else begin
            wpipe_vld_q <= sample_take;
            wpipe_mag_q <= prod[MAG_W+7:8];
        end
    end

    assign acc_vld   = wpipe_vld_q;
    assign acc_mag   = wpipe_mag_q;
    assign pipe_busy = wpipe_vld_q;
`else
    logic unused_coff;

    assign unused_coff = ^Coheren_Coff;
    assign acc_vld     = sample_take;
    assign acc_mag     = mag;
    assign pipe_busy   = 1'b0;
`endif

    // State register
    always_ff @(posedge AD_CLK) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; the gate is only watched for a new line in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gate_rise) state_d = ST_ACQ;
            ST_ACQ:   if (!So_Gate && !pipe_busy) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!out_valid_q && fifo_empty)  state_d = ST_IDLE;
                else if (xfer && out_last_q)     state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output control: refill the output register whenever it is free or
    // being consumed; the word read out while one entry remains is the last
    always_comb begin
        rd_en       = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (state_q == ST_DRAIN && (!out_valid_q || xfer)) begin
            if (!fifo_empty) begin
                rd_en       = 1'b1;
                out_valid_d = 1'b1;
                out_last_d  = fifo_one_left;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    // Window peak / count; emit a word on the DECIM-th sample or at flush
    always_comb begin
        cur_max = line_start ? '0 : max_q;
        cur_cnt = line_start ? '0 : cnt_q;
        new_max = (acc_mag > cur_max) ? acc_mag : cur_max;
        max_d   = cur_max;
        cnt_d   = cur_cnt;
        wr_en   = 1'b0;
        wr_word = sat_out(cur_max, OUT_SHIFT);
        if (acc_vld) begin
            if (cur_cnt == CNT_W'(DECIM - 1)) begin
                wr_en   = 1'b1;
                wr_word = sat_out(new_max, OUT_SHIFT);
                max_d   = '0;
                cnt_d   = '0;
            end else begin
                max_d   = new_max;
                cnt_d   = cur_cnt + CNT_W'(1);
            end
        end else if (state_q == ST_FLUSH) begin
            wr_en = (cur_cnt != '0);
            max_d = '0;
            cnt_d = '0;
        end
    end

    // Datapath and status registers
    always_ff @(posedge AD_CLK) begin
        if (Reset) begin
            gate_prev_q <= 1'b0;
            max_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_line_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            gate_prev_q <= So_Gate;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (line_start) begin
                out_line_q <= Line_Num;
                ovf_q      <= 1'b0;
            end else if (wr_en && fifo_full) begin
                ovf_q      <= 1'b1;
            end
        end
    end

    line_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_line_fifo (
        .clk      (AD_CLK),
        .srst     (Reset),
        .wr_en    (wr_en),
        .wr_data  (wr_word),
        .rd_en    (rd_en),
        .rd_data  (Out_Data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .one_left (fifo_one_left)
    );

    assign Out_Valid = out_valid_q;
    assign Out_Last  = out_last_q;
    assign Out_Line  = out_line_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_echo_decim.sv
// Directed bench for echo_decim (DECIM=8, DEPTH=4, OUT_SHIFT=6).
// Expected words follow the COHERENCE_WEIGHT_EN build setting.
module tb_echo_decim;

    logic        AD_CLK;
    logic        Reset;
    logic        So_Gate;
    logic [14:0] DAS_Value;
    logic [7:0]  Coheren_Coff;
    logic [7:0]  Line_Num;
    logic [7:0]  Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Out_Last;
    logic [7:0]  Out_Line;
    logic        Ovf;

    int          n_vec = 0;
    int          n_err = 0;

    logic [14:0] samp_q[$];
    logic [7:0]  got_data [16];
    int          got_n;

    echo_decim #(
        .DECIM     (8),
        .DEPTH     (4),
        .OUT_SHIFT (6)
    ) dut (
        .AD_CLK       (AD_CLK),
        .Reset        (Reset),
        .So_Gate      (So_Gate),
        .DAS_Value    (DAS_Value),
        .Coheren_Coff (Coheren_Coff),
        .Line_Num     (Line_Num),
        .Out_Data     (Out_Data),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Out_Last     (Out_Last),
        .Out_Line     (Out_Line),
        .Ovf          (Ovf)
    );

    initial AD_CLK = 1'b0;
    always #5 AD_CLK = ~AD_CLK;

    // Expected output word for a given window peak magnitude
    function automatic int exp_word(input int mag, input int coff);
        int w;
`ifdef COHERENCE_WEIGHT_EN
        w = (mag * coff) >> 8;
`else
        w = mag + 0 * coff;
`endif
        w = w >> 6;
        return (w > 255) ? 255 : w;
    endfunction

    task automatic tick();
        @(posedge AD_CLK);
        #1;
    endtask

    task automatic send_line(input logic [7:0] line, input logic [7:0] coff);
        Line_Num     = line;
        Coheren_Coff = coff;
        So_Gate      = 1'b1;
        for (int i = 0; i < samp_q.size(); i++) begin
            DAS_Value = samp_q[i];
            tick();
        end
        So_Gate   = 1'b0;
        DAS_Value = '0;
    endtask

    // Accept words until Out_Last; optionally stall every other cycle
    task automatic collect(input bit toggle);
        bit         done;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        got_n      = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            Out_Ready = toggle ? (c % 2 == 1) : 1'b1;
            if (prev_stall) begin
                n_vec++;
                if (Out_Valid !== 1'b1 || Out_Data !== prev_data || Out_Last !== prev_last) begin
                    $display("FAIL stall_hold: valid=%b data=%0d last=%b, required valid=1 data=%0d last=%b",
                             Out_Valid, Out_Data, Out_Last, prev_data, prev_last);
                    n_err++;
                end
            end
            if (Out_Valid && Out_Ready) begin
                if (got_n < 16) got_data[got_n] = Out_Data;
                got_n++;
                if (Out_Last) done = 1'b1;
            end
            prev_stall = Out_Valid && !Out_Ready;
            prev_data  = Out_Data;
            prev_last  = Out_Last;
            tick();
        end
        Out_Ready = 1'b1;
        n_vec++;
        if (!done) begin
            $display("FAIL drain_timeout: no Out_Last transfer within 200 cycles (words=%0d)", got_n);
            n_err++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        n_vec += 5;
        if (Out_Valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", Out_Valid); n_err++; end
        if (Out_Last  !== 1'b0) begin $display("FAIL rst_last: got %b want 0", Out_Last); n_err++; end
        if (Out_Data  !== 8'd0) begin $display("FAIL rst_data: got %0d want 0", Out_Data); n_err++; end
        if (Out_Line  !== 8'd0) begin $display("FAIL rst_line: got %0d want 0", Out_Line); n_err++; end
        if (Ovf       !== 1'b0) begin $display("FAIL rst_ovf: got %b want 0", Ovf); n_err++; end
        Reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_alternating();
        int w;
        samp_q.delete();
        for (int i = 0; i < 16; i++) samp_q.push_back((i % 2 == 0) ? 15'(1000) : 15'(-2000));
        send_line(8'h11, 8'd255);
        collect(1'b0);
        w = exp_word(2000, 255);
        n_vec++;
        if (got_n !== 2) begin $display("FAIL alt_count: got %0d want 2", got_n); n_err++; end
        for (int i = 0; i < 2 && i < got_n; i++) begin
            n_vec++;
            if (got_data[i] !== 8'(w)) begin $display("FAIL alt_word%0d: got %0d want %0d", i, got_data[i], w); n_err++; end
        end
        n_vec += 2;
        if (Out_Line !== 8'h11) begin $display("FAIL alt_line: got %0h want 11", Out_Line); n_err++; end
        if (Ovf !== 1'b0) begin $display("FAIL alt_ovf: got %b want 0", Ovf); n_err++; end
        repeat (2) tick();
    endtask

    task automatic test_saturation();
        int w;
        samp_q.delete();
        for (int i = 0; i < 10; i++) samp_q.push_back(15'(-16384));
        send_line(8'h22, 8'd255);
        collect(1'b0);
        w = exp_word(16383, 255);
        n_vec++;
        if (got_n !== 2) begin $display("FAIL sat_count: got %0d want 2", got_n); n_err++; end
        for (int i = 0; i < 2 && i < got_n; i++) begin
            n_vec++;
            if (got_data[i] !== 8'(w)) begin $display("FAIL sat_word%0d: got %0d want %0d", i, got_data[i], w); n_err++; end
        end
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        int w;
        samp_q.delete();
        for (int i = 0; i < 48; i++) samp_q.push_back(15'(640));
        send_line(8'h33, 8'd255);
        collect(1'b0);
        w = exp_word(640, 255);
        n_vec += 3;
        if (got_n !== 4) begin $display("FAIL ovf_count: got %0d want 4", got_n); n_err++; end
        if (Ovf !== 1'b1) begin $display("FAIL ovf_flag: got %b want 1", Ovf); n_err++; end
        if (Out_Line !== 8'h33) begin $display("FAIL ovf_line: got %0h want 33", Out_Line); n_err++; end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            n_vec++;
            if (got_data[i] !== 8'(w)) begin $display("FAIL ovf_word%0d: got %0d want %0d", i, got_data[i], w); n_err++; end
        end
        repeat (2) tick();
    endtask

    task automatic test_stall();
        int w;
        samp_q.delete();
        for (int i = 0; i < 24; i++) begin
            w = ((i / 8) + 5) * 64;
            samp_q.push_back((i % 2 == 0) ? 15'(w) : 15'(-w));
        end
        send_line(8'h44, 8'd255);
        collect(1'b1);
        n_vec += 2;
        if (got_n !== 3) begin $display("FAIL stall_count: got %0d want 3", got_n); n_err++; end
        if (Ovf !== 1'b0) begin $display("FAIL stall_ovf: got %b want 0", Ovf); n_err++; end
        for (int i = 0; i < 3 && i < got_n; i++) begin
            w = exp_word((i + 5) * 64, 255);
            n_vec++;
            if (got_data[i] !== 8'(w)) begin $display("FAIL stall_word%0d: got %0d want %0d", i, got_data[i], w); n_err++; end
        end
        repeat (2) tick();
    endtask

    task automatic test_coherence();
        int w;
        samp_q.delete();
        for (int i = 0; i < 8; i++) samp_q.push_back((i % 2 == 0) ? 15'(8000) : 15'(-8000));
        send_line(8'h55, 8'd128);
        collect(1'b0);
        w = exp_word(8000, 128);
        n_vec++;
        if (got_n !== 1) begin $display("FAIL coh_count: got %0d want 1", got_n); n_err++; end
        if (got_n >= 1) begin
            n_vec++;
            if (got_data[0] !== 8'(w)) begin $display("FAIL coh_word: got %0d want %0d", got_data[0], w); n_err++; end
        end
        Coheren_Coff = 8'd255;
        repeat (2) tick();
    endtask

    task automatic test_reset_drain();
        bit seen;
        int w;
        samp_q.delete();
        for (int i = 0; i < 24; i++) samp_q.push_back(15'(((i / 8) + 5) * 64));
        send_line(8'h40, 8'd255);
        Out_Ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (Out_Valid) seen = 1'b1;
            else tick();
        end
        n_vec++;
        if (!seen) begin $display("FAIL rd_first_valid: no word within 20 cycles"); n_err++; end
        w = exp_word(5 * 64, 255);
        n_vec++;
        if (Out_Data !== 8'(w)) begin $display("FAIL rd_first_word: got %0d want %0d", Out_Data, w); n_err++; end
        tick();
        Reset     = 1'b1;
        Out_Ready = 1'b0;
        tick();
        n_vec += 2;
        if (Out_Valid !== 1'b0) begin $display("FAIL rd_valid_after_rst: got %b want 0", Out_Valid); n_err++; end
        if (Out_Last !== 1'b0) begin $display("FAIL rd_last_after_rst: got %b want 0", Out_Last); n_err++; end
        Reset = 1'b0;
        repeat (2) tick();
        samp_q.delete();
        for (int i = 0; i < 8; i++) samp_q.push_back(15'(192));
        send_line(8'h41, 8'd255);
        collect(1'b0);
        w = exp_word(192, 255);
        n_vec += 2;
        if (got_n !== 1) begin $display("FAIL rd_next_count: got %0d want 1", got_n); n_err++; end
        if (Out_Line !== 8'h41) begin $display("FAIL rd_next_line: got %0h want 41", Out_Line); n_err++; end
        if (got_n >= 1) begin
            n_vec++;
            if (got_data[0] !== 8'(w)) begin $display("FAIL rd_next_word: got %0d want %0d", got_data[0], w); n_err++; end
        end
        repeat (2) tick();
    endtask

    task automatic test_gate_in_drain();
        bit stray;
        int w;
        samp_q.delete();
        for (int i = 0; i < 8; i++) samp_q.push_back(15'(128));
        send_line(8'h50, 8'd255);
        Out_Ready = 1'b0;
        repeat (4) tick();
        Line_Num  = 8'h51;
        So_Gate   = 1'b1;
        DAS_Value = 15'(1000);
        repeat (4) tick();
        So_Gate   = 1'b0;
        tick();
        collect(1'b0);
        w = exp_word(128, 255);
        n_vec += 3;
        if (got_n !== 1) begin $display("FAIL gid_count: got %0d want 1", got_n); n_err++; end
        if (Out_Line !== 8'h50) begin $display("FAIL gid_line: got %0h want 50", Out_Line); n_err++; end
        if (Ovf !== 1'b0) begin $display("FAIL gid_ovf: got %b want 0", Ovf); n_err++; end
        if (got_n >= 1) begin
            n_vec++;
            if (got_data[0] !== 8'(w)) begin $display("FAIL gid_word: got %0d want %0d", got_data[0], w); n_err++; end
        end
        stray = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (Out_Valid) stray = 1'b1;
            tick();
        end
        n_vec++;
        if (stray !== 1'b0) begin $display("FAIL gid_stray_output: got valid=1 want no output"); n_err++; end
    endtask

    initial begin
        Reset        = 1'b1;
        So_Gate      = 1'b0;
        DAS_Value    = '0;
        Coheren_Coff = 8'd255;
        Line_Num     = '0;
        Out_Ready    = 1'b1;
        test_reset();
        test_alternating();
        test_saturation();
        test_overflow();
        test_stall();
        test_coherence();
        test_reset_drain();
        test_gate_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
